// File: rtl/i2s_transmitter.sv
// Mono I2S playback sink: saturates 32-bit pushes to 16 bits, queues them, and emits one
// word per 64-BCLK frame on both channels. Pushes are never stalled; a push into a full FIFO is dropped.

module i2s_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count
);
    // Head is read combinationally; caller must not push when full unless popping,
    // and must not pop when empty.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

module i2s_transmitter #(
    parameter int BCLK_DIV   = 18,
    parameter int FRAC_BITS  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [31:0]                   audio_in,
    input  logic                          audio_valid_in,
    output logic                          i2s_bclk_out,
    output logic                          i2s_lrclk_out,
    output logic                          i2s_data_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          underflow_out,
    output logic                          overflow_out
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]   r_div_cnt;
    logic [5:0]         r_bit_cnt;
    logic [15:0]        r_hold;
    logic               r_bclk;
    logic               r_lrclk;
    logic               r_data;
    logic               r_underflow;
    logic               r_overflow;

    logic signed [31:0] w_shifted;
    logic [15:0]        w_sat;
    logic [15:0]        w_head;
    logic [CNT_W-1:0]   w_count;
    logic [5:0]         w_bit_nxt;
    logic [3:0]         w_idx;
    logic               w_div_end;
    logic               w_fall;
    logic               w_frame_start;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_data_nxt;

    assign w_shifted = $signed(audio_in) >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shifted[15:0];
        if (w_shifted > 32'sd32767) begin
            w_sat = 16'h7FFF;
        end else if (w_shifted < -32'sd32768) begin
            w_sat = 16'h8000;
        end
    end

    assign w_div_end     = (r_div_cnt == DIV_LAST);
    assign w_fall        = w_div_end && r_bclk;
    assign w_bit_nxt     = r_bit_cnt + 6'd1;
    assign w_frame_start = w_fall && (r_bit_cnt == 6'd63);
    assign w_empty       = (w_count == '0);
    assign w_full        = (w_count == CNT_W'(FIFO_DEPTH));
    // Pop decision uses the pre-push occupancy, so a push into an empty FIFO at frame start still underflows.
    assign w_pop         = w_frame_start && !w_empty;
    assign w_push        = audio_valid_in && (!w_full || w_pop);

    i2s_sample_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_push     (w_push),
        .i_push_dat (w_sat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    // Slot n carries hold[16-n] (left) or hold[48-n] (right); both reduce to -n mod 16.
    assign w_idx = 4'd0 - w_bit_nxt[3:0];

    always_comb begin
        w_data_nxt = 1'b0;
        if ((w_bit_nxt >= 6'd1 && w_bit_nxt <= 6'd16) ||
            (w_bit_nxt >= 6'd33 && w_bit_nxt <= 6'd48)) begin
            w_data_nxt = r_hold[w_idx];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_div_cnt   <= '0;
            r_bclk      <= 1'b0;
            r_bit_cnt   <= 6'd63;
            r_lrclk     <= 1'b1;
            r_data      <= 1'b0;
            r_hold      <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_underflow <= 1'b0;
            r_overflow  <= audio_valid_in && w_full && !w_pop;
            if (w_div_end) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrclk   <= w_bit_nxt[5];
                r_data    <= w_data_nxt;
                if (w_frame_start) begin
                    r_hold      <= w_empty ? 16'h0000 : w_head;
                    r_underflow <= w_empty;
                end
            end
        end
    end

    assign i2s_bclk_out   = r_bclk;
    assign i2s_lrclk_out  = r_lrclk;
    assign i2s_data_out   = r_data;
    assign fifo_count_out = w_count;
    assign underflow_out  = r_underflow;
    assign overflow_out   = r_overflow;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter with default parameters (frame = 2304 clk, BCLK = 36 clk).
module tb_i2s_transmitter;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] audio_in = 32'h0;
    logic        audio_valid_in = 1'b0;
    logic        i2s_bclk_out;
    logic        i2s_lrclk_out;
    logic        i2s_data_out;
    logic [2:0]  fifo_count_out;
    logic        underflow_out;
    logic        overflow_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    i2s_transmitter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .audio_in       (audio_in),
        .audio_valid_in (audio_valid_in),
        .i2s_bclk_out   (i2s_bclk_out),
        .i2s_lrclk_out  (i2s_lrclk_out),
        .i2s_data_out   (i2s_data_out),
        .fifo_count_out (fifo_count_out),
        .underflow_out  (underflow_out),
        .overflow_out   (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        if (cyc > target) begin
            errors++;
            $display("FAIL goto observed=%0d expected=%0d", cyc, target);
        end
        while (cyc < target) tick();
    endtask

    task automatic push(input logic [31:0] w);
        audio_in       = w;
        audio_valid_in = 1'b1;
        tick();
        audio_valid_in = 1'b0;
    endtask

    function automatic int fs(input int k);
        return 36 + 2304 * k;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_bclk"},  {31'd0, i2s_bclk_out},  32'd0);
        check({tag, "_lrclk"}, {31'd0, i2s_lrclk_out}, 32'd1);
        check({tag, "_data"},  {31'd0, i2s_data_out},  32'd0);
        check({tag, "_count"}, {29'd0, fifo_count_out}, 32'd0);
        check({tag, "_uf"},    {31'd0, underflow_out}, 32'd0);
        check({tag, "_of"},    {31'd0, overflow_out},  32'd0);
    endtask

    // Collects slots 1..16 and 33..48 of the frame starting at edge f.
    task automatic capture(input int f, input logic [15:0] exp, input string tag);
        logic [15:0] l;
        logic [15:0] r;
        l = 16'h0;
        r = 16'h0;
        for (int n = 1; n <= 16; n++) begin
            goto(f + 36 * n);
            l[16 - n] = i2s_data_out;
        end
        check({tag, "_lr_left"}, {31'd0, i2s_lrclk_out}, 32'd0);
        for (int n = 33; n <= 48; n++) begin
            goto(f + 36 * n);
            r[48 - n] = i2s_data_out;
        end
        check({tag, "_lr_right"}, {31'd0, i2s_lrclk_out}, 32'd1);
        check({tag, "_left"},  {16'd0, l}, {16'd0, exp});
        check({tag, "_right"}, {16'd0, r}, {16'd0, exp});
    endtask

    initial begin
        tick(); tick(); tick();
        check_reset("rst");
        rst_in = 1'b0;
        cyc = 0;

        goto(17);  check("bclk_e17", {31'd0, i2s_bclk_out}, 32'd0);
        goto(18);  check("bclk_e18", {31'd0, i2s_bclk_out}, 32'd1);
        goto(36);
        check("bclk_e36",  {31'd0, i2s_bclk_out},  32'd0);
        check("lrclk_e36", {31'd0, i2s_lrclk_out}, 32'd0);
        check("uf_f0",     {31'd0, underflow_out}, 32'd1);
        goto(37);  check("uf_f0_end", {31'd0, underflow_out}, 32'd0);
        push(32'h0000_1234);
        check("count_1234", {29'd0, fifo_count_out}, 32'd1);
        goto(54);  check("bclk_e54", {31'd0, i2s_bclk_out}, 32'd1);
        capture(fs(0), 16'h0000, "f0_silent");

        goto(fs(1));
        check("uf_f1",    {31'd0, underflow_out}, 32'd0);
        check("count_f1", {29'd0, fifo_count_out}, 32'd0);
        capture(fs(1), 16'h1234, "f1");

        push(32'h0001_0000);
        push(32'hFFFE_0000);
        check("count_sat", {29'd0, fifo_count_out}, 32'd2);
        goto(fs(2));
        check("uf_f2",    {31'd0, underflow_out}, 32'd0);
        check("count_f2", {29'd0, fifo_count_out}, 32'd1);
        capture(fs(2), 16'h7FFF, "f2_satpos");
        goto(fs(3));
        check("uf_f3", {31'd0, underflow_out}, 32'd0);
        capture(fs(3), 16'h8000, "f3_satneg");

        push(32'h0000_7FFF);
        push(32'hFFFF_8000);
        push(32'hFFFF_FFFF);
        push(32'h0000_0001);
        check("count_full", {29'd0, fifo_count_out}, 32'd4);
        check("of_full",    {31'd0, overflow_out},  32'd0);
        push(32'h0000_5555);
        check("of_drop",       {31'd0, overflow_out},  32'd1);
        check("count_drop",    {29'd0, fifo_count_out}, 32'd4);
        tick();
        check("of_drop_end",   {31'd0, overflow_out},  32'd0);

        goto(fs(4) - 1);
        push(32'h0000_00A5);
        check("of_pushpop",    {31'd0, overflow_out},  32'd0);
        check("count_pushpop", {29'd0, fifo_count_out}, 32'd4);
        check("uf_f4",         {31'd0, underflow_out}, 32'd0);
        capture(fs(4), 16'h7FFF, "f4_w1");
        capture(fs(5), 16'h8000, "f5_w2");
        capture(fs(6), 16'hFFFF, "f6_w3");
        capture(fs(7), 16'h0001, "f7_w4");
        goto(fs(8));
        check("uf_f8",    {31'd0, underflow_out}, 32'd0);
        check("count_f8", {29'd0, fifo_count_out}, 32'd0);
        capture(fs(8), 16'h00A5, "f8_w5");

        push(32'hFFFF_FFFF);
        push(32'h0000_0002);
        push(32'h0000_0003);
        push(32'h0000_0004);
        goto(fs(9));
        check("count_f9", {29'd0, fifo_count_out}, 32'd3);
        goto(fs(9) + 36 * 5 + 2);
        check("data_f9_n5",  {31'd0, i2s_data_out},  32'd1);
        check("lrclk_f9_n5", {31'd0, i2s_lrclk_out}, 32'd0);
        #2;
        rst_in = 1'b1;
        #1;
        check_reset("arst");
        tick(); tick();
        rst_in = 1'b0;
        cyc = 0;

        goto(35);
        push(32'h0000_0F0F);
        check("uf_post_rst",    {31'd0, underflow_out}, 32'd1);
        check("count_post_rst", {29'd0, fifo_count_out}, 32'd1);
        check("lrclk_post_rst", {31'd0, i2s_lrclk_out}, 32'd0);
        tick();
        check("uf_post_rst_end", {31'd0, underflow_out}, 32'd0);
        capture(fs(0), 16'h0000, "pr_f0");
        goto(fs(1));
        check("uf_pr_f1",    {31'd0, underflow_out}, 32'd0);
        check("count_pr_f1", {29'd0, fifo_count_out}, 32'd0);
        capture(fs(1), 16'h0F0F, "pr_f1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
